set_less_than_unit: RTL

//  Multi-cycle, parametrised set-less-than unit; next generation of the single-cycle SLTU block.

---
 rtl/set_less_than_unit_pkg.sv | 20 ++
 rtl/set_less_than_unit_if.sv | 27 ++
 rtl/set_less_than_unit_chunk_cmp.sv | 12 +
 rtl/set_less_than_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/set_less_than_unit_pkg.sv
// Shared types and constants for the multi-cycle set-less-than unit.
// The relation vector is ordered {lt,eq,gt}.
package slt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } sltState_t;

  localparam logic [2:0] SET_LT = 3'b100;
  localparam logic [2:0] SET_EQ = 3'b010;
  localparam logic [2:0] SET_GT = 3'b001;

  // The chunk counter needs at least one bit even when there is a single chunk.
  function automatic int cntWidth(input int nChunk);
    return (nChunk > 1) ? $clog2(nChunk) : 1;
  endfunction

endpackage

// File: rtl/set_less_than_unit_if.sv
// Request/result handshake bundle between the ALU issue stage (master)
// and the set-less-than unit (slave).
interface set_less_than_unit_if #(
  parameter int WIDTH = 32
);

  logic             iValid;
  logic             oReady;
  logic             iSigned;
  logic [WIDTH-1:0] iDataA;
  logic [WIDTH-1:0] iDataB;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oData;
  logic [2:0]       oSet;

  modport master (
    output iValid, iSigned, iDataA, iDataB, iReady,
    input  oReady, oValid, oData, oSet
  );

  modport slave (
    input  iValid, iSigned, iDataA, iDataB, iReady,
    output oReady, oValid, oData, oSet
  );

endinterface

// File: rtl/set_less_than_unit_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice, producing {lt,eq,gt}.
module slt_chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [2:0]       rel
);

  assign rel = {(a < b), (a == b), (a > b)};

endmodule

// File: rtl/set_less_than_unit.sv
// Multi-cycle SLT/SLTU unit comparing operands MSB-first, CHUNK bits per cycle.
// Define SLT_EARLY_EXIT_EN to leave the compare phase at the first unequal chunk.
module set_less_than_unit
  import slt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                 iClk,
  input logic                 iRst,
  set_less_than_unit_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cntWidth(NCHUNK);

  sltState_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [2:0]       relReg;
  logic             cmpDone;
  logic [CHUNK-1:0] chunkA;
  logic [CHUNK-1:0] chunkB;
  logic [2:0]       chunkRel;
  logic             lastChunk;
  logic [WIDTH-1:0] signFlip;

  // Signed compare becomes unsigned once both sign bits are inverted.
  assign signFlip  = {bus.iSigned, {(WIDTH-1){1'b0}}};
  assign lastChunk = (cnt == CW'(NCHUNK - 1));

  always_comb begin
    int sel;
    sel    = NCHUNK - 1 - int'(cnt);
    chunkA = opA[sel*CHUNK +: CHUNK];
    chunkB = opB[sel*CHUNK +: CHUNK];
  end

  slt_chunk_cmp #(.CHUNK(CHUNK)) uChunkCmp (
    .a   (chunkA),
    .b   (chunkB),
    .rel (chunkRel)
  );

  // The chunk decision is registered in relReg first; cmpDone then spends one
  // more cycle publishing it, which gives the NCHUNK+1 (or k+2) latency.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      cnt        <= '0;
      opA        <= '0;
      opB        <= '0;
      relReg     <= SET_EQ;
      cmpDone    <= 1'b0;
      bus.oReady <= 1'b1;
      bus.oValid <= 1'b0;
      bus.oData  <= '0;
      bus.oSet   <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.iValid) begin
            opA        <= bus.iDataA ^ signFlip;
            opB        <= bus.iDataB ^ signFlip;
            cnt        <= '0;
            relReg     <= SET_EQ;
            cmpDone    <= 1'b0;
            bus.oReady <= 1'b0;
            state      <= CMP;
          end
        end
        CMP: begin
          if (cmpDone) begin
            bus.oData  <= {{(WIDTH-1){1'b0}}, (relReg == SET_LT)};
            bus.oSet   <= relReg;
            bus.oValid <= 1'b1;
            state      <= DONE;
          end else begin
`ifdef SLT_EARLY_EXIT_EN
            relReg <= chunkRel;
            if ((chunkRel != SET_EQ) || lastChunk) begin
              cmpDone <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
`else
            if (relReg == SET_EQ) begin
              relReg <= chunkRel;
            end
            if (lastChunk) begin
              cmpDone <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
`endif
          end
        end
        DONE: begin
          if (bus.iReady) begin
            bus.oValid <= 1'b0;
            bus.oReady <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
